// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin / fixed-select registered multiplexer.
package rr_mux_pkg;

    localparam int   N_CH_DEF   = 4;
    localparam int   WIDTH_DEF  = 8;
    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Converts a one-hot vector of up to 16 channels to its index; all-zero maps to 0.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] onehot);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            idx = idx | ({4{onehot[i]}} & 4'(i));
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating priority picker: grants the first requester strictly after ptr, wrapping modulo N_CH.
module rr_prio_pick #(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  gnt
);

    logic [SEL_W-1:0] pos_s;
    logic             found_s;

    // Scan ptr+1 .. ptr+N_CH; the last offset revisits ptr itself so a lone requester still wins.
    always_comb begin
        gnt     = '0;
        found_s = 1'b0;
        pos_s   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            pos_s      = SEL_W'((int'(ptr) + k) % N_CH);
            gnt[pos_s] = req[pos_s] & ~found_s;
            found_s    = found_s | req[pos_s];
        end
    end

endmodule

// File: rtl/rr_mux_reg.sv
// N-channel registered multiplexer with valid/ready handshake, round-robin or fixed-select grant.
module rr_mux_reg
    import rr_mux_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEL_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    input  logic                  out_ready
);

    logic [N_CH-1:0]  sel_onehot_s;
    logic [N_CH-1:0]  elig_s;
    logic [N_CH-1:0]  gnt_s;
    logic             load_s;
    logic [WIDTH-1:0] gnt_data_s;
    logic [15:0]      gnt_ext_s;
    logic [SEL_W-1:0] gnt_idx_s;
    logic [SEL_W-1:0] ptr_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [SEL_W-1:0] out_ch_r;

    // Eligible set: a sel beyond the last channel matches nothing, so nothing is granted.
    always_comb begin
        sel_onehot_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel_onehot_s[i] = (sel == SEL_W'(i));
        end
        if (mode == MODE_FIXED) begin
            elig_s = in_valid & sel_onehot_s;
        end else begin
            elig_s = in_valid;
        end
    end

    // In fixed mode elig_s is already one-hot or empty, so the picker passes it through unchanged.
    rr_prio_pick #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_pick (
        .req (elig_s),
        .ptr (ptr_r),
        .gnt (gnt_s)
    );

    // Handshake: the register can take a beat when empty or draining this cycle.
    always_comb begin
        load_s = ~out_valid_r | out_ready;
        if (rst) begin
            in_ready = '0;
        end else if (load_s) begin
            in_ready = gnt_s;
        end else begin
            in_ready = '0;
        end
    end

    // AND-OR select of the granted channel's data and its index.
    always_comb begin
        gnt_data_s = '0;
        gnt_ext_s  = 16'h0000;
        for (int i = 0; i < N_CH; i++) begin
            gnt_data_s   = gnt_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt_s[i]}});
            gnt_ext_s[i] = gnt_s[i];
        end
        gnt_idx_s = SEL_W'(onehot_to_idx(gnt_ext_s));
    end

    // Output register and round-robin pointer; everything holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ch_r    <= '0;
            ptr_r       <= SEL_W'(N_CH - 1);
        end else if (load_s) begin
            if (|gnt_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= gnt_data_s;
                out_ch_r    <= gnt_idx_s;
                ptr_r       <= gnt_idx_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;

endmodule
